chimp_box_drawer: RTL

//  Draws one chimp-test grid box: box indices (col,row) -> stream of VGA pixel writes.

---
 rtl/chimp_pkg.sv | 25 ++
 rtl/chimp_box_origin.sv | 20 ++
 rtl/chimp_box_drawer.sv | 97 +++++++++
 3 files changed

// File: rtl/chimp_pkg.sv
// rtl/chimp_pkg.sv - chimp-test grid geometry, widths and drawer state encoding
package chimp_pkg;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 5;
    localparam int COLOUR_W = 3;

    // Shared with the mouse hit-test decoder so box edges line up exactly.
    localparam int X_ORIGIN = 17;
    localparam int X_PITCH  = 37;
    localparam int Y_ORIGIN = 8;
    localparam int Y_PITCH  = 28;
    localparam int BOX_W    = 20;
    localparam int BOX_H    = 20;
    localparam int GRID_N   = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } drawStateT;

endpackage

// File: rtl/chimp_box_origin.sv
// rtl/chimp_box_origin.sv - box (col,row) to top-left pixel via shift-add multiply
module chimp_box_origin
    import chimp_pkg::*;
(
    input  logic [IDX_W-1:0] boxX,
    input  logic [IDX_W-1:0] boxY,
    output logic [X_W-1:0]   baseX,
    output logic [Y_W-1:0]   baseY
);

    always_comb begin
        baseX = X_W'(X_ORIGIN);
        baseY = Y_W'(Y_ORIGIN);
        for (int i = 0; i < IDX_W; i++) begin
            if (boxX[i]) baseX = baseX + (X_W'(X_PITCH) << i);
            if (boxY[i]) baseY = baseY + (Y_W'(Y_PITCH) << i);
        end
    end

endmodule

// File: rtl/chimp_box_drawer.sv
// rtl/chimp_box_drawer.sv - rasterises one chimp-test grid box into VGA pixel writes
module chimp_box_drawer
    import chimp_pkg::*;
(
    input  logic                clk,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [IDX_W-1:0]    iBoxX,
    input  logic [IDX_W-1:0]    iBoxY,
    input  logic [COLOUR_W-1:0] iColour,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(BOX_W - 1);
    localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(BOX_H - 1);

    drawStateT        state;
    logic [X_W-1:0]   originX, baseX;
    logic [Y_W-1:0]   originY, baseY;
    logic [CNT_W-1:0] cx, cy, nextCx, nextCy;

    chimp_box_origin uOrigin (
        .boxX  (iBoxX),
        .boxY  (iBoxY),
        .baseX (originX),
        .baseY (originY)
    );

    // cx/cy track the pixel currently on the outputs; next* is the one registered this edge.
    always_comb begin
        nextCx = cx + CNT_W'(1);
        nextCy = cy;
        if (cx == LAST_X) begin
            nextCx = '0;
            nextCy = cy + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state   <= IDLE;
            baseX   <= '0;
            baseY   <= '0;
            cx      <= '0;
            cy      <= '0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        // First pixel goes out on the accept edge itself.
                        baseX   <= originX;
                        baseY   <= originY;
                        oX      <= originX;
                        oY      <= originY;
                        oColour <= iColour;
                        oPlot   <= 1'b1;
                        oBusy   <= 1'b1;
                        cx      <= '0;
                        cy      <= '0;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    if (cx == LAST_X && cy == LAST_Y) begin
                        oPlot <= 1'b0;
                        oDone <= 1'b1;
                        state <= DONE;
                    end else begin
                        oPlot <= 1'b1;
                        oX    <= baseX + X_W'(nextCx);
                        oY    <= baseY + Y_W'(nextCy);
                        cx    <= nextCx;
                        cy    <= nextCy;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
